// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants for the register file.
package regfile_pkg;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT = 32;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_reg32.sv
// regfile_reg32: one storage register with load enable and async active-low clear.
module regfile_reg32
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32 register file, two combinational read ports, one synchronous write port.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    localparam int N = 2 ** ADDR_WIDTH;

    logic [N-1:1] we;
    logic [N-1:0][DATA_WIDTH-1:0] regs;

    // one-hot write decode; address 0 has no enable so its writes vanish
    always_comb
        for (int i = 1; i < N; i++)
            we[i] = RegWrite && (WriteRegister == ADDR_WIDTH'(i));

    assign regs[ZERO_REG] = '0;

    for (genvar g = 1; g < N; g++) begin : g_reg
        regfile_reg32 #(.WIDTH(DATA_WIDTH)) u_reg (
            .clk  (Clk),
            .rst_n(Reset_n),
            .en   (we[g]),
            .d    (WriteData),
            .q    (regs[g])
        );
    end

    assign ReadData1 = regs[ReadRegister1];
    assign ReadData2 = regs[ReadRegister2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array model.
module tb_regfile;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [4:0]  ReadRegister1 = '0, ReadRegister2 = '0, WriteRegister = '0;
    logic [31:0] WriteData = '0;
    logic        RegWrite = 1'b0;
    logic [31:0] ReadData1, ReadData2;

    int total = 0;
    int bad = 0;
    bit chk = 1'b0;
    logic [31:0] mdl [32] = '{default: 32'h0};

    regfile dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 Clk = ~Clk;

    // reference: an array that takes the write on each enabled edge; reg 0 never stored
    always @(posedge Clk)
        if (Reset_n === 1'b1 && RegWrite && WriteRegister != 5'd0) mdl[WriteRegister] = WriteData;

    always @(negedge Reset_n)
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge Clk)
        if (chk) begin
            check("rd1", ReadData1, mdl[ReadRegister1]);
            check("rd2", ReadData2, mdl[ReadRegister2]);
        end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1;
        WriteRegister = a;
        WriteData = d;
        @(posedge Clk);
        #2;
        RegWrite = 1'b0;
    endtask

    task automatic rd_both(input string nm, input logic [4:0] a, input logic [31:0] exp);
        ReadRegister1 = a;
        ReadRegister2 = a;
        #1;
        check({nm, "_p1"}, ReadData1, exp);
        check({nm, "_p2"}, ReadData2, exp);
    endtask

    initial begin
        #12;
        Reset_n = 1'b1;
        chk = 1'b1;
        for (int i = 0; i < 32; i++) rd_both("reset_all", 5'(i), 32'h0);
        @(posedge Clk);
        #2;
        wr(5'd2, 32'd42);
        rd_both("w42", 5'd2, 32'd42);
        check("model_r2", mdl[2], 32'd42);
        wr(5'd2, 32'd15);
        rd_both("w15", 5'd2, 32'd15);
        RegWrite = 1'b0;
        WriteRegister = 5'd2;
        WriteData = 32'd99;
        @(posedge Clk);
        #2;
        rd_both("no_we", 5'd2, 32'd15);
        wr(5'd3, 32'd25);
        rd_both("iso_r2", 5'd2, 32'd15);
        rd_both("iso_r3", 5'd3, 32'd25);
        wr(5'd0, 32'd25);
        rd_both("zero", 5'd0, 32'd0);
        check("model_r0", mdl[0], 32'd0);
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'd25);
            rd_both("sweep25", 5'(i), 32'd25);
            wr(5'(i), 32'd323);
            rd_both("sweep323", 5'(i), 32'd323);
        end
        check("model_r31", mdl[31], 32'd323);
        Reset_n = 1'b0;
        rd_both("async_rst", 5'd31, 32'd0);
        for (int i = 0; i < 32; i++) rd_both("rst_sweep", 5'(i), 32'h0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        wr(5'd5, 32'd1234);
        rd_both("pre_rst", 5'd5, 32'd1234);
        RegWrite = 1'b1;
        WriteRegister = 5'd5;
        WriteData = 32'd77;
        #1;
        Reset_n = 1'b0;
        @(posedge Clk);
        #2;
        RegWrite = 1'b0;
        Reset_n = 1'b1;
        rd_both("rst_wins", 5'd5, 32'd0);
        wr(5'd7, 32'd555);
        rd_both("first_after_rst", 5'd7, 32'd555);
        repeat (400) begin
            @(posedge Clk);
            #2;
            WriteRegister = 5'($urandom);
            WriteData = $urandom;
            RegWrite = 1'($urandom);
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                #1 Reset_n = 1'b0;
                #1 Reset_n = 1'b1;
            end
        end
        @(posedge Clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
